// File: rtl/esd_pkg.sv
// Shared ESD definitions: sequencer state encoding, system clock rate and time conversion.
// Used by the output sequencer, the ESD core and the watchdog.
package esd_pkg;

    typedef enum logic [2:0] {
        StOff,
        StPrechk,
        StEnable,
        StConfirm,
        StDwell,
        StRun,
        StFault
    } seq_state_t;

    localparam int unsigned CLK_HZ = 50_000_000;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return ms * (CLK_HZ / 1000);
    endfunction

endpackage

// File: rtl/esd_delay_timer.sv
// Loadable down-counter with a zero flag; load wins over dec and the count saturates at zero.
module esd_delay_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/esd_output_sequencer.sv
// Staged enable of N_CH safety outputs with per-channel feedback confirmation and fault latching.
// Define ESD_SEQ_RUN_MONITOR_EN to keep supervising feedback once all channels are on.
module esd_output_sequencer
    import esd_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned STEP_CYCLES = ms_to_cycles(1),
    parameter int unsigned FB_CYCLES   = ms_to_cycles(1) / 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shutdown_in,
    input  logic                  fault_clr,
    input  logic [N_CH-1:0]       fb_in,
    output logic [N_CH-1:0]       ch_en,
    output logic                  seq_busy,
    output logic                  all_on,
    output logic                  fault,
    output logic [$clog2(N_CH):0] fault_ch,
    output logic                  trip_req
);

    localparam int unsigned MAX_CYC = (STEP_CYCLES > FB_CYCLES) ? STEP_CYCLES : FB_CYCLES;
    localparam int unsigned TW      = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned KW      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CW      = $clog2(N_CH) + 1;

    localparam logic [TW-1:0] FB_LOAD   = TW'(FB_CYCLES - 1);
    localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_CYCLES - 1);
    localparam logic [KW-1:0] K_LAST    = KW'(N_CH - 1);
    localparam logic [CW-1:0] CH_PRECHK = CW'(N_CH);

    seq_state_t    state;
    logic [KW-1:0] k;
    logic          t_load;
    logic          t_dec;
    logic          t_zero;
    logic [TW-1:0] t_value;

    esd_delay_timer #(
        .W (TW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (t_load),
        .value (t_value),
        .dec   (t_dec),
        .zero  (t_zero)
    );

`ifdef ESD_SEQ_RUN_MONITOR_EN
    logic [CW-1:0] low_bad;

    always_comb begin
        low_bad = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (!fb_in[i]) low_bad = CW'(i);
        end
    end
`endif

    // In RUN the timer is held preloaded while feedback is healthy, so the
    // FB_CYCLES-th consecutive mismatching cycle is the one that sees zero.
    always_comb begin
        t_load  = 1'b0;
        t_dec   = 1'b0;
        t_value = FB_LOAD;
        case (state)
            StEnable: t_load = 1'b1;
            StConfirm: begin
                if (fb_in[k]) begin
                    t_load  = 1'b1;
                    t_value = STEP_LOAD;
                end else begin
                    t_dec = 1'b1;
                end
            end
            StDwell: begin
                if (t_zero) t_load = 1'b1;
                else        t_dec  = 1'b1;
            end
`ifdef ESD_SEQ_RUN_MONITOR_EN
            StRun: begin
                if (fb_in != '1) t_dec  = 1'b1;
                else             t_load = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StOff;
            k        <= '0;
            ch_en    <= '0;
            seq_busy <= 1'b0;
            all_on   <= 1'b0;
            fault    <= 1'b0;
            fault_ch <= '0;
            trip_req <= 1'b0;
        end else if (state == StFault) begin
            if (fault_clr && shutdown_in) begin
                state    <= StOff;
                fault    <= 1'b0;
                fault_ch <= '0;
                trip_req <= 1'b0;
            end
        end else if (shutdown_in) begin
            // Shutdown outranks every other transition, including a confirm timeout.
            state    <= StOff;
            ch_en    <= '0;
            seq_busy <= 1'b0;
            all_on   <= 1'b0;
        end else begin
            case (state)
                StOff: begin
                    if (!fault) begin
                        state    <= StPrechk;
                        seq_busy <= 1'b1;
                    end
                end
                StPrechk: begin
                    if (fb_in != '0) begin
                        state    <= StFault;
                        ch_en    <= '0;
                        seq_busy <= 1'b0;
                        fault    <= 1'b1;
                        trip_req <= 1'b1;
                        fault_ch <= CH_PRECHK;
                    end else begin
                        k     <= '0;
                        state <= StEnable;
                    end
                end
                StEnable: begin
                    ch_en[k] <= 1'b1;
                    state    <= StConfirm;
                end
                StConfirm: begin
                    if (fb_in[k]) begin
                        state <= StDwell;
                    end else if (t_zero) begin
                        state    <= StFault;
                        ch_en    <= '0;
                        seq_busy <= 1'b0;
                        fault    <= 1'b1;
                        trip_req <= 1'b1;
                        fault_ch <= CW'(k);
                    end
                end
                StDwell: begin
                    if (t_zero) begin
                        if (k == K_LAST) begin
                            state    <= StRun;
                            seq_busy <= 1'b0;
                            all_on   <= 1'b1;
                        end else begin
                            k     <= k + 1'b1;
                            state <= StEnable;
                        end
                    end
                end
                StRun: begin
`ifdef ESD_SEQ_RUN_MONITOR_EN
                    if ((fb_in != '1) && t_zero) begin
                        state    <= StFault;
                        ch_en    <= '0;
                        all_on   <= 1'b0;
                        fault    <= 1'b1;
                        trip_req <= 1'b1;
                        fault_ch <= low_bad;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
